marv32_alu_arbiter: RTL and testbench

Shares the single combinational marv32 ALU between two requesters, port 0 and port 1 (e.g. the execute stage and the address/branch helper), using round-robin arbitration. Each port uses a valid/ready handshake. The granted operands are driven through an internal `marv32_alu` instance, and the result is captured in a one-entry output register tagged with the requester ID. The block sits between the requesters and the writeback/bypass logic and provides one cycle of latency with full backpressure support.

---
 rtl/marv32_alu_arbiter.sv | 107 ++++++++++
 tb/tb_marv32_alu_arbiter.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/marv32_alu_arbiter.sv
// Round-robin arbiter sharing one combinational marv32 ALU between two
// valid/ready requesters, with a one-entry tagged result register.

module marv32_alu #(
   parameter int XLEN = 32
) (
   input  logic [XLEN-1:0] op_1,
   input  logic [XLEN-1:0] op_2,
   input  logic [3:0]      opcode,
   output logic [XLEN-1:0] result
);

   logic signed [XLEN-1:0] op_1_s;
   logic signed [XLEN-1:0] op_2_s;
   logic        [4:0]      shamt;

   assign op_1_s = op_1;
   assign op_2_s = op_2;
   assign shamt  = op_2[4:0];

   always_comb begin
      result = '0;
      case (opcode[2:0])
         3'b000:  result = opcode[3] ? (op_1 - op_2) : (op_1 + op_2);
         3'b001:  result = op_1 << shamt;
         3'b010:  result = {{(XLEN-1){1'b0}}, (op_1_s < op_2_s)};
         3'b011:  result = {{(XLEN-1){1'b0}}, (op_1 < op_2)};
         3'b100:  result = op_1 ^ op_2;
         3'b101:  result = opcode[3] ? XLEN'(op_1_s >>> shamt) : (op_1 >> shamt);
         3'b110:  result = op_1 | op_2;
         default: result = op_1 & op_2;
      endcase
   end

endmodule

module marv32_alu_arbiter #(
   parameter int XLEN = 32
) (
   input  logic            clk_in,
   input  logic            rst_n_in,
   input  logic            req0_valid_in,
   output logic            req0_ready_out,
   input  logic [XLEN-1:0] req0_op_1_in,
   input  logic [XLEN-1:0] req0_op_2_in,
   input  logic [3:0]      req0_opcode_in,
   input  logic            req1_valid_in,
   output logic            req1_ready_out,
   input  logic [XLEN-1:0] req1_op_1_in,
   input  logic [XLEN-1:0] req1_op_2_in,
   input  logic [3:0]      req1_opcode_in,
   output logic            res_valid_out,
   output logic [XLEN-1:0] res_data_out,
   output logic            res_id_out,
   input  logic            res_ready_in
);

   logic            last_grant;
   logic            grant0;
   logic            grant1;
   logic            can_accept;
   logic            accept;
   logic            winner;
   logic [XLEN-1:0] alu_op_1;
   logic [XLEN-1:0] alu_op_2;
   logic [3:0]      alu_opcode;
   logic [XLEN-1:0] alu_result;

   // A lone valid port always wins; on contention the port not granted last wins.
   assign grant0     = req0_valid_in & (~req1_valid_in | last_grant);
   assign grant1     = req1_valid_in & (~req0_valid_in | ~last_grant);
   assign can_accept = ~res_valid_out | res_ready_in;

   assign req0_ready_out = grant0 & can_accept;
   assign req1_ready_out = grant1 & can_accept;
   assign accept         = req0_ready_out | req1_ready_out;
   assign winner         = req1_ready_out;

   assign alu_op_1   = winner ? req1_op_1_in   : req0_op_1_in;
   assign alu_op_2   = winner ? req1_op_2_in   : req0_op_2_in;
   assign alu_opcode = winner ? req1_opcode_in : req0_opcode_in;

   marv32_alu #(.XLEN(XLEN)) u_alu (
      .op_1   (alu_op_1),
      .op_2   (alu_op_2),
      .opcode (alu_opcode),
      .result (alu_result)
   );

   // Result stage: overwrite on accept (covers drain+accept), else drain when consumed.
   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         res_valid_out <= 1'b0;
         res_data_out  <= '0;
         res_id_out    <= 1'b0;
         last_grant    <= 1'b1;
      end else if (accept) begin
         res_valid_out <= 1'b1;
         res_data_out  <= alu_result;
         res_id_out    <= winner;
         last_grant    <= winner;
      end else if (res_ready_in) begin
         res_valid_out <= 1'b0;
      end
   end

endmodule

// File: tb/tb_marv32_alu_arbiter.sv
// Directed bench for marv32_alu_arbiter: handshake, round-robin order,
// backpressure, ALU wrap/shift cases and asynchronous reset.

module tb_marv32_alu_arbiter;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        req0_valid, req1_valid;
   logic        req0_ready, req1_ready;
   logic [31:0] req0_op_1, req0_op_2, req1_op_1, req1_op_2;
   logic [3:0]  req0_opcode, req1_opcode;
   logic        res_valid;
   logic [31:0] res_data;
   logic        res_id;
   logic        res_ready;

   int n_cmp = 0;
   int n_mis = 0;

   always #5 clk = ~clk;

   marv32_alu_arbiter #(.XLEN(32)) dut (
      .clk_in         (clk),
      .rst_n_in       (rst_n),
      .req0_valid_in  (req0_valid),
      .req0_ready_out (req0_ready),
      .req0_op_1_in   (req0_op_1),
      .req0_op_2_in   (req0_op_2),
      .req0_opcode_in (req0_opcode),
      .req1_valid_in  (req1_valid),
      .req1_ready_out (req1_ready),
      .req1_op_1_in   (req1_op_1),
      .req1_op_2_in   (req1_op_2),
      .req1_opcode_in (req1_opcode),
      .res_valid_out  (res_valid),
      .res_data_out   (res_data),
      .res_id_out     (res_id),
      .res_ready_in   (res_ready)
   );

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_mis++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Lone request on one port; expects same-cycle ready and a result after the edge.
   task automatic single(input bit port, input logic [31:0] a, input logic [31:0] b,
                         input logic [3:0] opc, input logic [31:0] exp, input string tag);
      req0_valid = (port == 1'b0);
      req1_valid = (port == 1'b1);
      if (port) begin
         req1_op_1 = a; req1_op_2 = b; req1_opcode = opc;
      end else begin
         req0_op_1 = a; req0_op_2 = b; req0_opcode = opc;
      end
      #1;
      check_val({tag, "_rdy0"}, 32'(req0_ready), 32'(!port));
      check_val({tag, "_rdy1"}, 32'(req1_ready), 32'(port));
      tick();
      check_val({tag, "_vld"},  32'(res_valid), 32'd1);
      check_val({tag, "_id"},   32'(res_id),    32'(port));
      check_val({tag, "_data"}, res_data,       exp);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n = 1'b0;
      req0_valid = 1'b0; req1_valid = 1'b0;
      req0_op_1 = '0; req0_op_2 = '0; req0_opcode = '0;
      req1_op_1 = '0; req1_op_2 = '0; req1_opcode = '0;
      res_ready = 1'b1;
      #2;
      check_val("rst_vld",  32'(res_valid), 32'd0);
      check_val("rst_data", res_data,       32'd0);
      check_val("rst_id",   32'(res_id),    32'd0);
      check_val("rst_rdy0", 32'(req0_ready), 32'd0);
      #10 rst_n = 1'b1;
      tick();

      single(1'b0, 32'd5, 32'd3, 4'b0000, 32'd8, "add");
      req0_valid = 1'b0;
      tick();
      check_val("drain_vld", 32'(res_valid), 32'd0);

      single(1'b0, 32'h8000_0000, 32'd4, 4'b1101, 32'hF800_0000, "sra");
      single(1'b0, 32'h8000_0000, 32'd4, 4'b0101, 32'h0800_0000, "srl");
      single(1'b1, 32'hFFFF_FFFF, 32'd1, 4'b0000, 32'd0, "wrap");
      single(1'b1, 32'd1, 32'h21, 4'b0001, 32'd2, "sll");

      // Contention: last grant was port 1, so port 0 leads and grants alternate.
      req0_valid = 1'b1; req0_op_1 = 32'd5; req0_op_2 = 32'd3; req0_opcode = 4'b1000;
      req1_valid = 1'b1; req1_op_1 = 32'hFFFF_FFFF; req1_op_2 = 32'd1; req1_opcode = 4'b0010;
      #1;
      for (int i = 0; i < 4; i++) begin
         check_val($sformatf("rr%0d_rdy0", i), 32'(req0_ready), 32'(i % 2 == 0));
         check_val($sformatf("rr%0d_rdy1", i), 32'(req1_ready), 32'(i % 2 == 1));
         tick();
         check_val($sformatf("rr%0d_vld", i),  32'(res_valid), 32'd1);
         check_val($sformatf("rr%0d_id", i),   32'(res_id),    32'(i % 2));
         check_val($sformatf("rr%0d_data", i), res_data, (i % 2 == 0) ? 32'd2 : 32'd1);
      end

      // Backpressure holds the port-1 result and blocks both ports.
      res_ready = 1'b0;
      #1;
      for (int i = 0; i < 3; i++) begin
         check_val($sformatf("bp%0d_rdy0", i), 32'(req0_ready), 32'd0);
         check_val($sformatf("bp%0d_rdy1", i), 32'(req1_ready), 32'd0);
         tick();
         check_val($sformatf("bp%0d_vld", i),  32'(res_valid), 32'd1);
         check_val($sformatf("bp%0d_id", i),   32'(res_id),    32'd1);
         check_val($sformatf("bp%0d_data", i), res_data,       32'd1);
      end
      res_ready = 1'b1;
      #1;
      check_val("bprel_rdy0", 32'(req0_ready), 32'd1);
      check_val("bprel_rdy1", 32'(req1_ready), 32'd0);
      tick();
      check_val("bprel_id",   32'(res_id), 32'd0);
      check_val("bprel_data", res_data,    32'd2);

      // Asynchronous reset while FULL and stalled.
      res_ready = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      check_val("arst_vld",  32'(res_valid), 32'd0);
      check_val("arst_data", res_data,       32'd0);
      check_val("arst_id",   32'(res_id),    32'd0);
      #2 rst_n = 1'b1;
      res_ready = 1'b1;
      #1;
      check_val("post_rst_rdy0", 32'(req0_ready), 32'd1);
      check_val("post_rst_rdy1", 32'(req1_ready), 32'd0);
      tick();
      check_val("post_rst_vld",  32'(res_valid), 32'd1);
      check_val("post_rst_id",   32'(res_id),    32'd0);
      check_val("post_rst_data", res_data,       32'd2);

      // Lone port 1 right after its own grant is not held off.
      tick();
      check_val("pre_lone_id", 32'(res_id), 32'd1);
      single(1'b1, 32'd7, 32'd3, 4'b0100, 32'd4, "lone1");
      req0_valid = 1'b0; req1_valid = 1'b0;
      tick();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule
